// File: rtl/counter_sched_ctrl_pkg.sv
// Shared types and helpers for the counter scheduling controller.
// The optional abort feature is selected with CNT_CTRL_ABORT_EN.
package cnt_ctrl_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefNreq  = 2;

    // Requester indices are at most 2 bits wide (NREQ is 2..4).
    localparam int unsigned IdxW = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDone,
        StAbort
    } state_e;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic logic [IdxW-1:0] onehot_to_idx(input logic [3:0] oh);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = IdxW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_sched_ctrl_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins. The pointer register lives in the controller.
module rr_arbiter
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [IdxW-1:0] o_win_idx,
    output logic            o_any
);

    int w_best_dist;
    int w_best_i;
    int w_dist;

    // Pick the requester with the smallest rotated distance from the pointer.
    always_comb begin
        w_best_dist = int'(NREQ);
        w_best_i    = -1;
        w_dist      = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_dist = (i + int'(NREQ) - int'(i_ptr)) % int'(NREQ);
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_i    = i;
            end
        end
        o_win = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            o_win[i] = (i == w_best_i);
        end
    end

    // Index and any-request flags derived from the one-hot winner.
    always_comb begin
        o_win_idx = onehot_to_idx(4'(o_win));
        o_any     = |i_req;
    end

endmodule

// File: rtl/counter_sched_ctrl.sv
// Round-robin scheduler that shares one external up-counter among NREQ
// requesters: grant, clear the counter, count to the owner's length, then
// pulse done and rotate priority.
// Define CNT_CTRL_ABORT_EN to cancel an interval when the owner drops req
// during LOAD or RUN (one-cycle abort pulse, no done).
module counter_sched_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_req_len,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_done,
    output logic                  o_abort,
    output logic                  o_busy,
    input  logic [WIDTH-1:0]      i_cnt_q,
    output logic                  o_cnt_clear_n,
    output logic                  o_cnt_enable
);

    state_e          r_state;
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] r_owner;
    logic [NREQ-1:0] r_grant;
    logic [WIDTH-1:0] r_target;
    logic            r_done;
    logic            r_abort;
    logic            r_busy;
    logic            r_clr;

    logic [NREQ-1:0] w_win;
    logic [IdxW-1:0] w_win_idx;
    logic            w_any;
    logic            w_at_target;
    logic [IdxW-1:0] w_next_ptr;
`ifdef CNT_CTRL_ABORT_EN
    logic            w_owner_req;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    // Compare and pointer-rotation helpers for the FSM.
    always_comb begin
        w_at_target = (i_cnt_q == r_target);
        w_next_ptr  = (int'(r_owner) == int'(NREQ) - 1) ? '0 : r_owner + 1'b1;
`ifdef CNT_CTRL_ABORT_EN
        w_owner_req = |(i_req & r_grant);
`endif
    end

    // Controller FSM with registered grant/done/abort/busy/clear outputs.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            r_busy   <= 1'b0;
            r_clr    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state  <= StLoad;
                        r_grant  <= w_win;
                        r_owner  <= w_win_idx;
                        r_target <= i_req_len[int'(w_win_idx)*int'(WIDTH) +: WIDTH];
                        r_busy   <= 1'b1;
                        r_clr    <= 1'b1;
                    end
                end
                StLoad: begin
`ifdef CNT_CTRL_ABORT_EN
                    if (!w_owner_req) begin
                        r_state <= StAbort;
                        r_abort <= 1'b1;
                        r_clr   <= 1'b1;
                    end else
`endif
                    begin
                        r_state <= StRun;
                        r_clr   <= 1'b0;
                    end
                end
                StRun: begin
`ifdef CNT_CTRL_ABORT_EN
                    if (!w_owner_req) begin
                        r_state <= StAbort;
                        r_abort <= 1'b1;
                        r_clr   <= 1'b1;
                    end else
`endif
                    if (w_at_target) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_next_ptr;
                end
`ifdef CNT_CTRL_ABORT_EN
                StAbort: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_clr   <= 1'b0;
                    r_ptr   <= w_next_ptr;
                end
`endif
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_clr   <= 1'b0;
                end
            endcase
        end
    end

    // Counter control: clear follows reset directly; enable stops at target.
    always_comb begin
        o_grant       = r_grant;
        o_done        = r_done;
        o_abort       = r_abort;
        o_busy        = r_busy;
        o_cnt_clear_n = i_clear & ~r_clr;
        o_cnt_enable  = (r_state == StRun) && !w_at_target;
    end

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Self-checking bench for counter_sched_ctrl with a stand-in counter and an
// interval-level reference model.
module tb_counter_sched_ctrl;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic                  done;
    logic                  abort;
    logic                  busy;
    logic [WIDTH-1:0]      cnt_q;
    logic                  cnt_clear_n;
    logic                  cnt_enable;

    counter_sched_ctrl #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .i_clock       (clk),
        .i_clear       (rst_n),
        .i_req         (req),
        .i_req_len     (req_len),
        .o_grant       (grant),
        .o_done        (done),
        .o_abort       (abort),
        .o_busy        (busy),
        .i_cnt_q       (cnt_q),
        .o_cnt_clear_n (cnt_clear_n),
        .o_cnt_enable  (cnt_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external counter: async active-low clear, count enable.
    always_ff @(posedge clk or negedge cnt_clear_n) begin
        if (!cnt_clear_n) cnt_q <= '0;
        else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: owner index (-1 when idle), cycles since grant, latched
    // target, priority pointer, abort-cycle flag and expected counter value.
    int m_owner = -1;
    int m_t     = 0;
    int m_tgt   = 0;
    int m_ptr   = 0;
    bit m_abrt  = 1'b0;
    int m_q     = 0;

    int cyc = 0;
    int g_cyc = 0;
    int last_lat = -1;
    logic [NREQ-1:0] prev_grant = '0;
    int n_done_seen = 0;
    int n_abort_seen = 0;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_abrt  = 1'b0;
        m_q     = 0;
    endtask

    task automatic model_step();
        int pick;
        pick = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (pick < 0 && req[c]) pick = c;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_t     = 0;
                m_tgt   = int'(req_len[pick*WIDTH +: WIDTH]);
                m_abrt  = 1'b0;
            end
        end else if (m_abrt || m_t == m_tgt + 2) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_abrt  = 1'b0;
        end else begin
`ifdef CNT_CTRL_ABORT_EN
            if (!req[m_owner]) m_abrt = 1'b1;
            else
`endif
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_grant;
        logic e_done, e_abort, e_busy, e_clrn, e_en;
        e_grant = '0;
        e_done  = 1'b0;
        e_abort = 1'b0;
        e_busy  = 1'b0;
        e_clrn  = 1'b1;
        e_en    = 1'b0;
        if (m_owner >= 0) begin
            e_grant = NREQ'(1 << m_owner);
            e_busy  = 1'b1;
            if (m_abrt) begin
                e_abort = 1'b1;
                e_clrn  = 1'b0;
                m_q     = 0;
            end else begin
                e_clrn = (m_t != 0);
                e_done = (m_t == m_tgt + 2);
                e_en   = (m_t >= 1) && (m_t <= m_tgt);
                if (m_t == 0) m_q = 0;
                else m_q = (m_t - 1 < m_tgt) ? m_t - 1 : m_tgt;
            end
        end
        check("grant", 32'(grant), 32'(e_grant));
        check("done", 32'(done), 32'(e_done));
        check("abort", 32'(abort), 32'(e_abort));
        check("busy", 32'(busy), 32'(e_busy));
        check("cnt_clear_n", 32'(cnt_clear_n), 32'(e_clrn));
        check("cnt_enable", 32'(cnt_enable), 32'(e_en));
        check("cnt_q", 32'(cnt_q), 32'(m_q));
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (grant != '0 && prev_grant == '0) g_cyc = cyc;
        if (done) begin
            last_lat = cyc - g_cyc;
            n_done_seen++;
        end
        if (abort) n_abort_seen++;
        prev_grant = grant;
        // Requesters hold req until their done pulse.
        if (m_owner >= 0 && !m_abrt && m_t == m_tgt + 2) req[m_owner] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_clear_n", 32'(cnt_clear_n), 32'h0);
        check("rst_cnt_q", 32'(cnt_q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_enable", 32'(cnt_enable), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_grant = '0;
    endtask

    task automatic wait_q(input logic [WIDTH-1:0] val, input logic [NREQ-1:0] own,
                          input string tag);
        int i;
        i = 0;
        while (i < 40 && !(cnt_q == val && grant == own && cnt_enable)) begin
            step();
            i++;
        end
        check(tag, 32'(i < 40), 32'h1);
    endtask

    initial begin
        rst_n   = 1'b1;
        req     = '0;
        req_len = '0;
        #1;
        @(negedge clk);
        do_reset();

        // Single request, length 5.
        req = 2'b01;
        req_len = {4'd0, 4'd5};
        repeat (12) step();
        check("lat_len5", 32'(last_lat), 32'd7);

        // Both requesting from reset: 0 (len 3) then 1 (len 2).
        do_reset();
        req = 2'b11;
        req_len = {4'd2, 4'd3};
        repeat (6) step();
        check("lat_len3", 32'(last_lat), 32'd5);
        repeat (8) step();
        check("lat_len2", 32'(last_lat), 32'd4);

        // Zero length on requester 1.
        req = 2'b10;
        req_len = {4'd0, 4'd7};
        repeat (6) step();
        check("lat_len0", 32'(last_lat), 32'd2);

        // Maximum length, no wrap.
        req = 2'b01;
        req_len = {4'd3, 4'd15};
        repeat (22) step();
        check("lat_len15", 32'(last_lat), 32'd17);

        // Reset in the middle of RUN, request still held.
        req = 2'b01;
        req_len = {4'd0, 4'd9};
        wait_q(4'd3, 2'b01, "reach_q3");
        do_reset();
        repeat (14) step();
        check("lat_after_rst", 32'(last_lat), 32'd11);

        // Owner drops req at cnt_q == 2 while requester 1 is pending.
        do_reset();
        n_done_seen  = 0;
        n_abort_seen = 0;
        req = 2'b11;
        req_len = {4'd2, 4'd6};
        wait_q(4'd2, 2'b01, "reach_q2");
        req[0] = 1'b0;
        repeat (20) step();
`ifdef CNT_CTRL_ABORT_EN
        check("drop_aborts", 32'(n_abort_seen), 32'd1);
        check("drop_dones", 32'(n_done_seen), 32'd1);
`else
        check("drop_aborts", 32'(n_abort_seen), 32'd0);
        check("drop_dones", 32'(n_done_seen), 32'd2);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) req = req | NREQ'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) req = req & NREQ'($urandom_range(0, 3));
            req_len = (NREQ*WIDTH)'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
